// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer.
package nibble_serial_adder_pkg;

    // Width of the reused ripple-carry slice.
    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_adder_cin.sv
// 4-bit ripple-carry adder with carry-in. Each bit position is one full-adder cell.
module nibble_adder_cin
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIB_W-1:0] in0,
    input  logic [NIB_W-1:0] in1,
    input  logic             cin,
    output logic [NIB_W-1:0] out,
    output logic             cout
);

    logic [NIB_W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < NIB_W; i++) begin : g_fa
        assign out[i]   = in0[i] ^ in1[i] ^ c[i];
        assign c[i + 1] = (in0[i] & in1[i]) | (c[i] & (in0[i] ^ in1[i]));
    end

    assign cout = c[NIB_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-precision add/subtract: one 4-bit slice is reused for NIB cycles, LSB nibble first.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for an operation; in_ready = 1
//   RUN   | processing nibble idx; partial result builds up in out
//   DONE  | result valid; out/cout/ovf held until out_ready
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf
);

    localparam int NIB   = WIDTH / NIB_W;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    if ((WIDTH < NIB_W) || ((WIDTH % NIB_W) != 0)) begin : g_width_check
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
    end

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               carry_q;
    logic [IDX_W-1:0]   idx_q;
    logic [NIB_W-1:0]   a_nib;
    logic [NIB_W-1:0]   b_nib;
    logic [NIB_W-1:0]   s_nib;
    logic               c_nib;
    logic               accept;
    logic               last;

    assign accept = in_valid & in_ready;
    assign last   = (idx_q == IDX_W'(NIB - 1));

    // Select the operand nibbles addressed by the current index.
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int i = 0; i < NIB; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_nib = a_q[i*NIB_W +: NIB_W];
                b_nib = b_q[i*NIB_W +: NIB_W];
            end
        end
    end

    nibble_adder_cin u_slice (
        .in0  (a_nib),
        .in1  (b_nib),
        .cin  (carry_q),
        .out  (s_nib),
        .cout (c_nib)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Handshake outputs; in_ready is also masked by rst so nothing is accepted during reset.
    always_comb begin
        in_ready  = (state == IDLE) & ~rst;
        out_valid = (state == DONE);
    end

    // Operand capture, nibble sequencing and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            out     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        // Subtraction is A + ~B + 1: invert B here and seed the carry with sub.
                        a_q     <= in0;
                        b_q     <= sub ? ~in1 : in1;
                        carry_q <= sub;
                        idx_q   <= '0;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NIB; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            out[i*NIB_W +: NIB_W] <= s_nib;
                        end
                    end
                    carry_q <= c_nib;
                    if (last) begin
                        cout <= c_nib;
                        ovf  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) & (s_nib[NIB_W-1] != a_q[WIDTH-1]);
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
